// File: rtl/nibble_serial_add_seq.sv
// Sequences a WIDTH-bit add through an external 4-bit adder, one nibble per clock.
// Operands are latched on start and the slice carry is chained between passes.
module nibble_serial_add_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic [3:0]       add_a_o,
    output logic [3:0]       add_b_o,
    output logic             add_cin_o,
    input  logic [3:0]       add_s_i,
    input  logic             add_cout_i
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IdxW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] part_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    // Slice select is driven only from registers, so start never reaches the adder inputs.
    always_comb begin
        add_a_o = 4'h0;
        add_b_o = 4'h0;
        part_d  = part_q;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == IdxW'(i)) begin
                add_a_o          = a_q[4*i +: 4];
                add_b_o          = b_q[4*i +: 4];
                part_d[4*i +: 4] = add_s_i;
            end
        end
    end

    assign add_cin_o = carry_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= cin_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    part_q  <= part_d;
                    carry_q <= add_cout_i;
                    if (idx_q == LastIdx) begin
                        // Final pass: publish the assembled sum including this nibble.
                        sum_q   <= part_d;
                        cout_q  <= add_cout_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule
